// File: rtl/iomem_arbiter.sv
// Two-requester (scalar/vector) arbiter in front of a single io memory port with bus locking.
// Define IOMEM_ARB_ROUND_ROBIN_EN for round-robin on contested cycles; otherwise scalar has fixed priority.
module iomem_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_req,
  input  logic          s_we,
  input  logic          s_lock,
  input  logic [31:0]   s_addr,
  input  logic [31:0]   s_wdata,
  output logic          s_gnt,
  output logic          s_rvalid,
  output logic [31:0]   s_rdata,
  input  logic          v_req,
  input  logic          v_we,
  input  logic          v_lock,
  input  logic [31:0]   v_addr,
  input  logic [63:0]   v_wdata,
  output logic          v_gnt,
  output logic          v_rvalid,
  output logic [127:0]  v_rdata,
  output logic          mem_we,
  output logic [31:0]   mem_address,
  output logic [31:0]   mem_data_input,
  output logic [63:0]   mem_vector_input,
  input  logic [31:0]   mem_data_output,
  input  logic [127:0]  mem_vector_output
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_S = 2'd1,
    LOCK_V = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   s_gnt_c, v_gnt_c;
  logic   prefer_v;
  logic   s_rd_q, v_rd_q;

`ifdef IOMEM_ARB_ROUND_ROBIN_EN
  // ptr_q high means the vector requester wins the next contested idle cycle
  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && s_req && v_req)
      ptr_d = ~ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_q <= 1'b0;
    else
      ptr_q <= ptr_d;
  end

  assign prefer_v = ptr_q;
`else
  assign prefer_v = 1'b0;
`endif

  always_comb begin
    s_gnt_c = 1'b0;
    v_gnt_c = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (s_req && v_req) begin
          v_gnt_c = prefer_v;
          s_gnt_c = ~prefer_v;
        end else begin
          s_gnt_c = s_req;
          v_gnt_c = v_req;
        end
        if (s_gnt_c && s_lock)
          state_d = LOCK_S;
        else if (v_gnt_c && v_lock)
          state_d = LOCK_V;
      end
      LOCK_S: begin
        s_gnt_c = s_req;
        if (!(s_req && s_lock))
          state_d = IDLE;
      end
      LOCK_V: begin
        v_gnt_c = v_req;
        if (!(v_req && v_lock))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Grants must drop the instant reset asserts, not at the next edge
    if (!rst_n) begin
      s_gnt_c = 1'b0;
      v_gnt_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_rd_q  <= 1'b0;
      v_rd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_rd_q  <= s_gnt_c & ~s_we;
      v_rd_q  <= v_gnt_c & ~v_we;
    end
  end

  assign s_gnt = s_gnt_c;
  assign v_gnt = v_gnt_c;

  assign mem_we           = (s_gnt_c & s_we) | (v_gnt_c & v_we);
  assign mem_address      = s_gnt_c ? s_addr : (v_gnt_c ? v_addr : 32'd0);
  assign mem_data_input   = s_gnt_c ? s_wdata : 32'd0;
  assign mem_vector_input = v_gnt_c ? v_wdata : 64'd0;

  // Memory read data arrives one cycle after the address, aligned with the registered read grant
  assign s_rvalid = s_rd_q;
  assign v_rvalid = v_rd_q;
  assign s_rdata  = s_rd_q ? mem_data_output : 32'd0;
  assign v_rdata  = v_rd_q ? mem_vector_output : 128'd0;

endmodule
